// File: rtl/sobel_gcd_regmap.sv
// sobel_gcd_regmap: register map and command stage behind the SPI slave.
// Decodes {addr, data} frames, builds GCD operands, runs the GCD handshake,
// buffers pixels toward the Sobel engine and captures Sobel results.
// Build option: define SOBEL_GCD_REGMAP_PIXEL_FIFO_EN for a FIFO_DEPTH-entry
// pixel FIFO; otherwise the pixel buffer is a single holding register.
module sobel_gcd_regmap #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [15:0]            rx_data_i,
  input  logic                   rx_valid_i,
  output logic [15:0]            tx_data_o,
  output logic [DATA_WIDTH-1:0]  gcd_a_o,
  output logic [DATA_WIDTH-1:0]  gcd_b_o,
  output logic                   gcd_enable_o,
  input  logic [DATA_WIDTH-1:0]  gcd_i,
  input  logic                   gcd_done_i,
  output logic [PIXEL_WIDTH-1:0] px_data_o,
  output logic                   px_valid_o,
  input  logic                   px_ready_i,
  input  logic [PIXEL_WIDTH-1:0] px_sobel_i,
  input  logic                   px_done_i
);

  localparam int NBYTES = DATA_WIDTH / 8;

  // Elaboration-time parameter sanity checks.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8 in 8..32");
  end
  if (PIXEL_WIDTH < 1 || PIXEL_WIDTH > 8) begin : g_bad_pixel_width
    $error("PIXEL_WIDTH must be in 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Frame fields and decoded strobes
  logic [7:0] addr_s;
  logic [7:0] data_s;
  logic       push_s;
  logic       pop_s;
  logic       push_ok_s;
  logic       px_full_s;
  logic       clear_s;
  logic [7:0] status_s;
  logic [7:0] read_byte_s;

  // Registered state
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   enable_q, enable_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic                   sval_q, sval_d;
  logic [7:0]             sobel_q, sobel_d;
  logic [7:0]             rsel_q, rsel_d;
  logic [15:0]            tx_q, tx_d;
  logic                   px_valid_q, px_valid_d;
  logic [PIXEL_WIDTH-1:0] px_data_q, px_data_d;

  assign addr_s       = rx_data_i[15:8];
  assign data_s       = rx_data_i[7:0];
  assign push_s       = rx_valid_i && (addr_s == 8'h30);
  assign pop_s        = px_valid_q && px_ready_i;
  assign push_ok_s    = push_s && (!px_full_s || pop_s);
  assign clear_s      = rx_valid_i && (addr_s == 8'h28) && data_s[1];

  assign tx_data_o    = tx_q;
  assign gcd_a_o      = op_a_q;
  assign gcd_b_o      = op_b_q;
  assign gcd_enable_o = enable_q;
  assign px_data_o    = px_data_q;
  assign px_valid_o   = px_valid_q;

  // Operand writes, control decode, GCD FSM and sticky flags
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    if (rx_valid_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (addr_s == (8'h20 + 8'(i))) begin
          op_a_d[i*8 +: 8] = data_s;
        end else if (addr_s == (8'h24 + 8'(i))) begin
          op_b_d[i*8 +: 8] = data_s;
        end else begin
          op_a_d[i*8 +: 8] = op_a_d[i*8 +: 8];
        end
      end
      if (addr_s == 8'h28) begin
        // Clear is applied before start so a combined write starts clean.
        if (data_s[1]) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          ovf_d  = 1'b0;
        end else begin
          done_d = done_d;
        end
        if (data_s[0]) begin
          if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = state_d;
        end
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_q;
    end
    if ((state_q == ST_RUN) && gcd_done_i) begin
      result_d = gcd_i;
      done_d   = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      result_d = result_d;
    end
    // A dropped push (full, no simultaneous pop) is an overflow.
    if (push_s && px_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    enable_d = (state_d == ST_RUN);
  end

  // Read select, Sobel capture and readback word
  always_comb begin
    rsel_d  = rsel_q;
    sval_d  = sval_q;
    sobel_d = sobel_q;
    if (rx_valid_i && (((addr_s >= 8'h40) && (addr_s <= 8'h43)) ||
                       (addr_s == 8'h50) || (addr_s == 8'h51))) begin
      rsel_d = addr_s;
      if (addr_s == 8'h50) begin
        sval_d = 1'b0;
      end else begin
        sval_d = sval_q;
      end
    end else begin
      rsel_d = rsel_q;
    end
    // A capture in the same cycle as the 0x50 select wins.
    if (px_done_i) begin
      sobel_d                  = 8'h00;
      sobel_d[PIXEL_WIDTH-1:0] = px_sobel_i;
      sval_d                   = 1'b1;
    end else begin
      sobel_d = sobel_d;
    end

    status_s = {2'b00, sval_q, ovf_q, px_full_s, err_q, done_q, (state_q == ST_RUN)};

    read_byte_s = 8'h00;
    case (rsel_q)
      8'h50:   read_byte_s = sobel_q;
      8'h51:   read_byte_s = status_s;
      default: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (rsel_q == (8'h40 + 8'(i))) begin
            read_byte_s = result_q[i*8 +: 8];
          end else begin
            read_byte_s = read_byte_s;
          end
        end
      end
    endcase
    tx_d = {status_s, read_byte_s};
  end

  // Control, GCD and readback registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      sval_q   <= 1'b0;
      sobel_q  <= 8'h00;
      rsel_q   <= 8'h51;
      tx_q     <= 16'h0000;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      sval_q   <= sval_d;
      sobel_q  <= sobel_d;
      rsel_q   <= rsel_d;
      tx_q     <= tx_d;
    end
  end

`ifdef SOBEL_GCD_REGMAP_PIXEL_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PIXEL_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_q, wr_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW:0]            cnt_q, cnt_d;

  assign px_full_s = (cnt_q == (PW+1)'(FIFO_DEPTH));

  // Circular FIFO next state; pointers wrap naturally at a power-of-two depth
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_q] = data_s[PIXEL_WIDTH-1:0];
      wr_d        = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    px_valid_d = (cnt_d != '0);
    px_data_d  = mem_d[rd_d];
  end

  // FIFO storage, pointers and registered head
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      px_valid_q <= 1'b0;
      px_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      px_valid_q <= px_valid_d;
      px_data_q  <= px_data_d;
    end
  end
`else
  assign px_full_s = px_valid_q;

  // Single holding register; a pop frees it for a same-cycle push
  always_comb begin
    if (push_ok_s) begin
      px_data_d  = data_s[PIXEL_WIDTH-1:0];
      px_valid_d = 1'b1;
    end else begin
      px_data_d  = px_data_q;
      px_valid_d = px_valid_q && !pop_s;
    end
  end

  // Holding register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      px_valid_q <= 1'b0;
      px_data_q  <= '0;
    end else begin
      px_valid_q <= px_valid_d;
      px_data_q  <= px_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_gcd_regmap.sv
// Directed self-checking bench for sobel_gcd_regmap.
module tb_sobel_gcd_regmap;

`ifdef SOBEL_GCD_REGMAP_PIXEL_FIFO_EN
  localparam int DEPTH_EFF = 4;
`else
  localparam int DEPTH_EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] rx_data_i;
  logic        rx_valid_i;
  logic [15:0] tx_data_o;
  logic [31:0] gcd_a_o;
  logic [31:0] gcd_b_o;
  logic        gcd_enable_o;
  logic [31:0] gcd_i;
  logic        gcd_done_i;
  logic [7:0]  px_data_o;
  logic        px_valid_o;
  logic        px_ready_i;
  logic [7:0]  px_sobel_i;
  logic        px_done_i;

  int checks = 0;
  int errors = 0;
  int idx;

  sobel_gcd_regmap #(.DATA_WIDTH(32), .PIXEL_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
    .gcd_enable_o(gcd_enable_o), .gcd_i(gcd_i), .gcd_done_i(gcd_done_i),
    .px_data_o(px_data_o), .px_valid_o(px_valid_o), .px_ready_i(px_ready_i),
    .px_sobel_i(px_sobel_i), .px_done_i(px_done_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] addr, input logic [7:0] data);
    rx_data_i  = {addr, data};
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, 32'(tx_data_o), 32'h0);
    check({tag, "_a"}, gcd_a_o, 32'h0);
    check({tag, "_b"}, gcd_b_o, 32'h0);
    check({tag, "_en"}, 32'(gcd_enable_o), 32'h0);
    check({tag, "_pv"}, 32'(px_valid_o), 32'h0);
    check({tag, "_pd"}, 32'(px_data_o), 32'h0);
  endtask

  initial begin
    reset_i = 1'b1; rx_data_i = 16'h0000; rx_valid_i = 1'b0;
    gcd_i = 32'h0; gcd_done_i = 1'b0; px_ready_i = 1'b0;
    px_sobel_i = 8'h00; px_done_i = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    reset_i = 1'b0;
    tick(); tick();
    check("idle_tx", 32'(tx_data_o), 32'h0000);

    // Operands, including an ignored unmapped write
    write(8'h20, 8'h30);
    write(8'h24, 8'h12);
    write(8'h2F, 8'h77);
    check("op_a", gcd_a_o, 32'h0000_0030);
    check("op_b", gcd_b_o, 32'h0000_0012);

    // Start; the model reports 6 in the fifth enabled cycle
    write(8'h28, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      check("gcd_en_run", 32'(gcd_enable_o), 32'h1);
      if (k == 5) begin
        gcd_done_i = 1'b1;
        gcd_i      = 32'd6;
      end
      tick();
    end
    gcd_done_i = 1'b0;
    check("gcd_en_drop", 32'(gcd_enable_o), 32'h0);
    write(8'h40, 8'h00);
    tick();
    check("gcd_result_tx", 32'(tx_data_o), 32'h0206);

    // Start while busy
    write(8'h28, 8'h01);
    write(8'h28, 8'h01);
    tick();
    check("busy_err_tx", 32'(tx_data_o), 32'h0506);
    check("busy_en", 32'(gcd_enable_o), 32'h1);
    gcd_i = 32'd9; gcd_done_i = 1'b1;
    tick();
    gcd_done_i = 1'b0;
    tick();
    check("done_err_tx", 32'(tx_data_o), 32'h0609);
    write(8'h28, 8'h02);
    tick();
    check("clear_tx", 32'(tx_data_o), 32'h0009);

    // Top operand byte
    write(8'h23, 8'hAB);
    check("op_a_byte3", gcd_a_o, 32'hAB00_0030);

    // Overfill the pixel buffer with ready low
    write(8'h30, 8'h11);
    check("px_first_valid", 32'(px_valid_o), 32'h1);
    check("px_first_data", 32'(px_data_o), 32'h11);
    for (int i = 1; i <= 4; i++) write(8'h30, 8'(8'h11 + i));
    write(8'h51, 8'h00);
    tick();
    check("px_full_ovf_tx", 32'(tx_data_o), 32'h1818);
    px_ready_i = 1'b1;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (px_valid_o) begin
        check("px_pop_data", 32'(px_data_o), 32'(8'h11 + idx));
        idx++;
      end
      tick();
    end
    px_ready_i = 1'b0;
    check("px_pop_count", 32'(idx), 32'(DEPTH_EFF));
    check("px_empty", 32'(px_valid_o), 32'h0);
    write(8'h28, 8'h02);
    tick();
    check("ovf_clear_tx", 32'(tx_data_o), 32'h0000);

    // Push and pop together while full
    for (int i = 0; i < DEPTH_EFF; i++) write(8'h30, 8'(8'h20 + i));
    px_ready_i = 1'b1;
    write(8'h30, 8'(8'h20 + DEPTH_EFF));
    px_ready_i = 1'b0;
    check("pushpop_valid", 32'(px_valid_o), 32'h1);
    check("pushpop_head", 32'(px_data_o), 32'h21);
    tick();
    check("pushpop_status", 32'(tx_data_o), 32'h0808);
    px_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    px_ready_i = 1'b0;
    check("drain_empty", 32'(px_valid_o), 32'h0);

    // Sobel capture and select
    px_sobel_i = 8'hA5; px_done_i = 1'b1;
    tick();
    px_done_i = 1'b0;
    tick();
    check("sval_set_tx", 32'(tx_data_o), 32'h2020);
    write(8'h50, 8'h00);
    tick();
    check("sobel_read_tx", 32'(tx_data_o), 32'h00A5);
    rx_data_i = 16'h5000; rx_valid_i = 1'b1;
    px_sobel_i = 8'h3C; px_done_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; px_done_i = 1'b0;
    tick();
    check("capture_wins_tx", 32'(tx_data_o), 32'h203C);

    // Reset in the middle of a run with a pixel buffered
    write(8'h30, 8'h55);
    write(8'h28, 8'h01);
    check("pre_reset_en", 32'(gcd_enable_o), 32'h1);
    check("pre_reset_pv", 32'(px_valid_o), 32'h1);
    reset_i = 1'b1;
    tick();
    check_reset_outputs("midrun_reset");
    reset_i = 1'b0;
    tick(); tick();
    check("post_reset_tx", 32'(tx_data_o), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
